if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode stage. It owns the PC and issues word fetches to instruction memory over a req/ack handshake. It presents {PC+4, instruction, valid} to decode, honours stall requests from the hazard unit, and redirects on a taken branch or jump with flush of the wrong-path instruction.

---
 rtl/if_stage.sv | 180 ++++++++++++++++++
 tb/tb_if_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction fetch stage with IF/ID register, req/ack memory
//             handshake, stall skid buffer and branch redirect with flush.
//             Optional macro IF_PERF_CNT_EN adds fetch/bubble counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFtoID_PC,
  output logic [31:0] IFtoID_inst,
  output logic        IFtoID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_bubble
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        req_en_q;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic [31:0] load_data;
  logic        load;
  logic        bubble;
  logic        unused_tgt_lsb;

  assign pc_plus4       = pc_q + 32'd4;
  assign redirect_pc    = {branch_target[31:2], 2'b00};
  assign unused_tgt_lsb = ^branch_target[1:0];

  // Requests start one edge after reset release; HOLD parks the bus.
  assign imem_req     = req_en_q && (state_q != S_HOLD);
  assign imem_addr    = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign IFtoID_PC    = id_pc_q;
  assign IFtoID_inst  = id_inst_q;
  assign IFtoID_valid = id_valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    skid_d      = skid_q;
    drop_addr_d = drop_addr_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
    load        = 1'b0;
    bubble      = 1'b0;
    load_data   = imem_rdata;

    case (state_q)
      S_REQ: begin
        if (!req_en_q) begin
          if (branch_taken) pc_d = redirect_pc;
        end else if (branch_taken) begin
          bubble = 1'b1;
          pc_d   = redirect_pc;
          if (!imem_ack) begin
            // The outstanding request must complete at its original address.
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            load = 1'b1;
          end
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          bubble  = 1'b1;
          pc_d    = redirect_pc;
          skid_d  = '0;
          state_d = S_REQ;
        end else if (!stall) begin
          load      = 1'b1;
          load_data = skid_q;
          state_d   = S_REQ;
        end
      end
      S_DROP: begin
        if (branch_taken) begin
          bubble = 1'b1;
          pc_d   = redirect_pc;
        end else if (imem_ack) begin
          state_d = S_REQ;
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (load) begin
      id_pc_d    = pc_plus4;
      id_inst_d  = load_data;
      id_valid_d = 1'b1;
      pc_d       = pc_plus4;
    end
    if (bubble) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      skid_q      <= '0;
      drop_addr_q <= '0;
      id_pc_q     <= '0;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
      req_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      skid_q      <= skid_d;
      drop_addr_q <= drop_addr_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
      req_en_q    <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_bubble_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (load)   perf_fetch_q  <= perf_fetch_q + 32'd1;
      if (bubble) perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end

  assign perf_fetch  = perf_fetch_q;
  assign perf_bubble = perf_bubble_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Self-checking bench for if_stage against a queue-based
//             fetch/flush reference model, directed then random stimulus.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] TAGW = 32'hA000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IFtoID_PC;
  logic [31:0] IFtoID_inst;
  logic        IFtoID_valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic        w_valid;
  logic        w_ack;
  logic        w_zero;
  logic [31:0] w_zero32;

  assign imem_rdata = imem_addr | TAGW;
  assign w_rdata    = w_addr | TAGW;
  assign w_ack      = 1'b1;
  assign w_zero     = 1'b0;
  assign w_zero32   = 32'h0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] pf_main, pb_main, pf_wrap, pb_wrap;
`endif

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IFtoID_PC(IFtoID_PC),
    .IFtoID_inst(IFtoID_inst), .IFtoID_valid(IFtoID_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch(pf_main), .perf_bubble(pb_main)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) u_wrap (
    .clk(clk), .rst(rst), .stall(w_zero), .branch_taken(w_zero),
    .branch_target(w_zero32), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .IFtoID_PC(w_pc),
    .IFtoID_inst(w_inst), .IFtoID_valid(w_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch(pf_wrap), .perf_bubble(pb_wrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the program counter, an optional held word, a pending
  // wrong-path fetch (with its address), and the contents of IF/ID.
  bit          m_started;
  logic [31:0] m_pc;
  logic [31:0] m_skid[$];
  bit          m_discard;
  logic [31:0] m_drop_addr;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_id_valid;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_req();
    return m_started && (m_skid.size() == 0);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_discard ? m_drop_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_started   = 0;
    m_pc        = 32'h0;
    m_skid.delete();
    m_discard   = 0;
    m_drop_addr = 32'h0;
    m_id_pc     = 32'h0;
    m_id_inst   = NOP;
    m_id_valid  = 1'b0;
  endtask

  task automatic model_load(input logic [31:0] word);
    m_id_pc    = m_pc + 32'd4;
    m_id_inst  = word;
    m_id_valid = 1'b1;
    m_pc       = m_pc + 32'd4;
  endtask

  task automatic model_step(input logic s, input logic b, input logic [31:0] t, input logic a);
    logic acc;
    acc = exp_req() && a;
    if (!m_started) begin
      m_started = 1;
    end else if (b) begin
      m_id_valid = 1'b0;
      m_id_inst  = NOP;
      if (m_skid.size() != 0) begin
        m_skid.delete();
      end else if (!m_discard && !acc) begin
        m_discard   = 1;
        m_drop_addr = m_pc;
      end
      m_pc = {t[31:2], 2'b00};
    end else if (m_skid.size() != 0) begin
      if (!s) model_load(m_skid.pop_front());
    end else if (m_discard) begin
      if (acc) m_discard = 0;
    end else if (acc) begin
      if (!s) model_load(m_pc | TAGW);
      else    m_skid.push_back(m_pc | TAGW);
    end else if (!s) begin
      m_id_valid = 1'b0;
      m_id_inst  = NOP;
    end
  endtask

  task automatic check_all();
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
    if (exp_req()) chk("imem_addr", imem_addr, exp_addr());
    chk("id_valid", {31'b0, IFtoID_valid}, {31'b0, m_id_valid});
    chk("id_inst", IFtoID_inst, m_id_inst);
    if (m_id_valid) chk("id_pc", IFtoID_PC, m_id_pc);
  endtask

  task automatic step(input logic s, input logic b, input logic [31:0] t, input logic a);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    imem_ack      = a;
    model_step(s, b, t, a);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; imem_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("reset_id_pc", IFtoID_PC, 32'h0);
    chk("reset_wrap_req", {31'b0, w_req}, 32'h0);
    rst = 1'b1;

    // Zero-wait streaming; the wrap instance starts at the top of memory.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("stream_pc_first", IFtoID_PC, 32'h4);
    chk("wrap_id_pc", w_pc, 32'h0);
    chk("wrap_inst", w_inst, 32'hFFFF_FFFC);
    chk("wrap_addr", w_addr, 32'h0);
    chk("wrap_valid", {31'b0, w_valid}, 32'h1);
    step(0, 0, 0, 1);
    chk("stream_pc_second", IFtoID_PC, 32'h8);

    // Stall with an acked fetch at 8 parks the word in the skid buffer.
    step(1, 0, 0, 1);
    chk("hold_req_low", {31'b0, imem_req}, 32'h0);
    chk("hold_frozen_inst", IFtoID_inst, 32'hA000_0004);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("release_inst", IFtoID_inst, 32'hA000_0008);
    chk("release_pc", IFtoID_PC, 32'hC);

    // Redirect while waiting: old request finishes at 12, then 0x100.
    step(0, 1, 32'h0000_0103, 0);
    chk("drop_old_addr", imem_addr, 32'hC);
    step(0, 0, 0, 1);
    chk("redirect_addr", imem_addr, 32'h100);
    chk("drop_invalid", {31'b0, IFtoID_valid}, 32'h0);
    step(0, 0, 0, 1);
    chk("redirect_inst", IFtoID_inst, 32'hA000_0100);
    chk("redirect_pc", IFtoID_PC, 32'h104);

    // Two-cycle ack latency gives two bubbles per instruction.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("slow_addr_stable", imem_addr, 32'h104 + 32'(4 * i));
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
    end
    chk("slow_last_inst", IFtoID_inst, 32'hA000_010C);

    // Asynchronous reset in the middle of a wait.
    step(0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_id_pc", IFtoID_PC, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 1);
    chk("restart_addr", imem_addr, 32'h0);
    step(0, 0, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           $urandom,
           ($urandom_range(0, 9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
